booth_pp_accumulator: RTL and testbench



---
 rtl/booth_pp_accumulator_if.sv | 27 ++
 rtl/booth_pp_accumulator.sv | 109 ++++++++++
 tb/tb_booth_pp_accumulator.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_pp_accumulator_if.sv
// Bus bundle for booth_pp_accumulator: partial-product input side,
// product output side and the FSM state for observation.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. A producer holds valid and its payload stable until that
// edge. A consumer may raise or drop ready at any time.
interface booth_pp_accumulator_if;
  logic              in_valid;
  logic              in_ready;
  logic [15:0][33:0] pp;          // pp[i] carries PPi, weight 2^(2i)
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       product;
  logic [1:0]        dbg_state;   // 0 idle, 1 accum, 2 done

  // Environment side: drives partial products, consumes the product.
  modport master (
    output in_valid, pp, out_ready,
    input  in_ready, out_valid, product, dbg_state
  );

  // Accumulator side.
  modport slave (
    input  in_valid, pp, out_ready,
    output in_ready, out_valid, product, dbg_state
  );
endinterface

// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator: reduces the sixteen 34-bit radix-4 Booth partial
// products of a signed 32x32 multiply to the 64-bit product, adding
// PPS_PER_CYCLE partial products per cycle.
// Optional feature macro: PP_ACC_EARLY_TERM_EN -- leave the accumulate phase
// as soon as every remaining group of the captured bank is zero.
module booth_pp_accumulator #(
  parameter int PPS_PER_CYCLE = 2
) (
  input logic                   clk,
  input logic                   rst,
  booth_pp_accumulator_if.slave bus
);

  localparam int         P        = PPS_PER_CYCLE;
  localparam int         N        = 16 / P;
  localparam logic [3:0] LAST_GRP = 4'(N - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  generate
    if (!(P == 1 || P == 2 || P == 4 || P == 8 || P == 16)) begin : g_bad_pps
      $error("booth_pp_accumulator: PPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  logic [1:0]        state;
  logic [3:0]        grp_idx;
  logic [63:0]       acc;
  logic [15:0][33:0] bank;
  logic [63:0]       grp_sum;
  logic [3:0]        pp_idx;
  logic [63:0]       pp_term;
  logic              early_done;

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.product   = acc;
  assign bus.dbg_state = state;

  // Bank is loaded only on an input handshake, so later changes on pp are ignored.
  always_ff @(posedge clk) begin
    if (bus.in_valid && bus.in_ready) begin
      bank <= bus.pp;
    end
  end

  // Sum of the current group: each PP sign-extended to 64 bits and shifted by 2*index.
  always_comb begin
    grp_sum = '0;
    pp_idx  = '0;
    pp_term = '0;
    for (int j = 0; j < P; j++) begin
      pp_idx  = 4'(32'(grp_idx) * P + j);
      pp_term = {{30{bank[pp_idx][33]}}, bank[pp_idx]};
      grp_sum = grp_sum + (pp_term << {pp_idx, 1'b0});
    end
  end

`ifdef PP_ACC_EARLY_TERM_EN
  // High when every group after the one being added this cycle is all zero.
  always_comb begin
    early_done = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if ((i / P) > int'(grp_idx) && bank[i] != '0) begin
        early_done = 1'b0;
      end
    end
  end
`else
  assign early_done = 1'b0;
`endif

  // Control FSM and accumulator: capture in IDLE, one group per ACCUM cycle, hold in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grp_idx <= '0;
      acc     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            acc     <= '0;
            grp_idx <= '0;
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          acc     <= acc + grp_sum;
          grp_idx <= grp_idx + 4'd1;
          if (grp_idx == LAST_GRP || early_done) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Bench for booth_pp_accumulator: four instances (P = 2, 1, 4, 16) share the
// partial-product bus; each has its own in_valid. Expected products and
// latencies are queued when a set is driven and popped when out_valid rises.
module tb_booth_pp_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0][33:0] pp_drv;
  logic [3:0]        iv;
  logic              out_ready_drv;

  booth_pp_accumulator_if bus2 ();
  booth_pp_accumulator_if bus1 ();
  booth_pp_accumulator_if bus4 ();
  booth_pp_accumulator_if bus16 ();

  assign bus2.pp  = pp_drv;  assign bus2.in_valid  = iv[0];  assign bus2.out_ready  = out_ready_drv;
  assign bus1.pp  = pp_drv;  assign bus1.in_valid  = iv[1];  assign bus1.out_ready  = out_ready_drv;
  assign bus4.pp  = pp_drv;  assign bus4.in_valid  = iv[2];  assign bus4.out_ready  = out_ready_drv;
  assign bus16.pp = pp_drv;  assign bus16.in_valid = iv[3];  assign bus16.out_ready = out_ready_drv;

  booth_pp_accumulator #(.PPS_PER_CYCLE(2))  u_dut2  (.clk(clk), .rst(rst), .bus(bus2.slave));
  booth_pp_accumulator #(.PPS_PER_CYCLE(1))  u_dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));
  booth_pp_accumulator #(.PPS_PER_CYCLE(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));
  booth_pp_accumulator #(.PPS_PER_CYCLE(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  logic [3:0]  ov;
  logic [3:0]  ir;
  logic [63:0] prod [4];
  logic [1:0]  st   [4];
  assign ov[0] = bus2.out_valid;  assign ir[0] = bus2.in_ready;  assign prod[0] = bus2.product;  assign st[0] = bus2.dbg_state;
  assign ov[1] = bus1.out_valid;  assign ir[1] = bus1.in_ready;  assign prod[1] = bus1.product;  assign st[1] = bus1.dbg_state;
  assign ov[2] = bus4.out_valid;  assign ir[2] = bus4.in_ready;  assign prod[2] = bus4.product;  assign st[2] = bus4.dbg_state;
  assign ov[3] = bus16.out_valid; assign ir[3] = bus16.in_ready; assign prod[3] = bus16.product; assign st[3] = bus16.dbg_state;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [63:0] exp_q [$];
  int          lat_q [$];

  function automatic int p_of(int d);
    case (d)
      0:       return 2;
      1:       return 1;
      2:       return 4;
      default: return 16;
    endcase
  endfunction

  function automatic logic [33:0] rand_pp();
    return {2'($urandom_range(3, 0)), 32'($urandom)};
  endfunction

  // Reference product: sum of sign-extended PPi * 4^i, modulo 2^64.
  function automatic logic [63:0] ref_prod(logic [15:0][33:0] v);
    logic [63:0] s;
    logic [63:0] t;
    s = '0;
    for (int i = 0; i < 16; i++) begin
      t = {{30{v[i][33]}}, v[i]};
      for (int k = 0; k < i; k++) t = t * 64'd4;
      s = s + t;
    end
    return s;
  endfunction

  // Edges from capture to out_valid.
  function automatic int ref_lat(int d, logic [15:0][33:0] v);
    int lat;
    lat = 16 / p_of(d);
`ifdef PP_ACC_EARLY_TERM_EN
    lat = 1;
    for (int i = 0; i < 16; i++) begin
      if (v[i] != '0 && (i / p_of(d)) + 1 > lat) lat = (i / p_of(d)) + 1;
    end
`endif
    return lat;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic queue_vec(input int d, input logic [63:0] exp_p);
    exp_q.push_back(exp_p);
    lat_q.push_back(ref_lat(d, pp_drv));
  endtask

  // Waits (bounded) for out_valid, then compares latency and product against the queue.
  task automatic wait_result(input int d, input string tag);
    int          cyc;
    logic [63:0] e;
    int          l;
    cyc = 0;
    while (ov[d] !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    check({tag, "_latency"}, 64'(cyc), 64'(l));
    check({tag, "_product"}, prod[d], e);
  endtask

  // Called #1 after the capture edge: drop valid, garble the bus, await result.
  task automatic finish_capture(input int d, input string tag);
    iv[d] = 1'b0;
    for (int i = 0; i < 16; i++) pp_drv[i] = rand_pp();
    wait_result(d, tag);
  endtask

  task automatic launch(input int d, input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(ir[d]), 64'd1);
    iv[d] = 1'b1;
    @(posedge clk); #1;
    finish_capture(d, tag);
  endtask

  task automatic release_out(input int d, input string tag);
    @(negedge clk);
    out_ready_drv = 1'b1;
    @(posedge clk); #1;
    out_ready_drv = 1'b0;
    check({tag, "_rel_out_valid"}, 64'(ov[d]), 64'd0);
    check({tag, "_rel_in_ready"}, 64'(ir[d]), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0][33:0] saved;
    logic [63:0]       hold_exp;

    rst = 1'b1; iv = '0; out_ready_drv = 1'b0; pp_drv = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(ov[0]), 64'd0);
    check("rst_product", prod[0], 64'd0);
    check("rst_in_ready", 64'(ir[0]), 64'd0);
    check("rst_state", 64'(st[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(ir[0]), 64'd1);

    // 3 x 5 via PP0=3, PP1=3
    @(negedge clk);
    pp_drv = '0; pp_drv[0] = 34'd3; pp_drv[1] = 34'd3;
    queue_vec(0, 64'h0000_0000_0000_000F);
    launch(0, "three_x_five");
    release_out(0, "three_x_five");

    // PP0 = -1
    @(negedge clk);
    pp_drv = '0; pp_drv[0] = 34'h3_FFFF_FFFF;
    queue_vec(0, 64'hFFFF_FFFF_FFFF_FFFF);
    launch(0, "minus_one");
    release_out(0, "minus_one");

    // Random set with the output held off for 5 cycles
    @(negedge clk);
    for (int i = 0; i < 16; i++) pp_drv[i] = rand_pp();
    saved    = pp_drv;
    hold_exp = ref_prod(saved);
    queue_vec(0, hold_exp);
    launch(0, "hold");
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("hold_product", prod[0], hold_exp);
      check("hold_out_valid", 64'(ov[0]), 64'd1);
      check("hold_in_ready", 64'(ir[0]), 64'd0);
    end
    release_out(0, "hold");

    // (-2^31) x (-2^31) via PP15 alone; leave it in DONE for the next step
    @(negedge clk);
    pp_drv = '0; pp_drv[15] = 34'h1_0000_0000;
    queue_vec(0, 64'h4000_0000_0000_0000);
    launch(0, "min_sq");

    // in_valid together with the DONE-state out_ready: capture waits one cycle
    @(negedge clk);
    for (int i = 0; i < 16; i++) pp_drv[i] = rand_pp();
    queue_vec(0, ref_prod(pp_drv));
    iv[0] = 1'b1;
    out_ready_drv = 1'b1;
    check("overlap_in_ready_done", 64'(ir[0]), 64'd0);
    @(posedge clk); #1;
    out_ready_drv = 1'b0;
    check("overlap_out_valid", 64'(ov[0]), 64'd0);
    check("overlap_in_ready_idle", 64'(ir[0]), 64'd1);
    @(posedge clk); #1;
    finish_capture(0, "overlap");
    release_out(0, "overlap");

    // Reset during the 4th accumulate cycle discards the in-flight product
    @(negedge clk);
    for (int i = 0; i < 16; i++) pp_drv[i] = rand_pp();
    pp_drv[15] = 34'h0_0000_0001;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", 64'(ov[0]), 64'd0);
    check("midrst_product", prod[0], 64'd0);
    check("midrst_in_ready", 64'(ir[0]), 64'd0);
    check("midrst_state", 64'(st[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready_after", 64'(ir[0]), 64'd1);
    for (int i = 0; i < 16; i++) pp_drv[i] = rand_pp();
    queue_vec(0, ref_prod(pp_drv));
    launch(0, "after_rst");
    release_out(0, "after_rst");

    // Sweep of all configurations: random full sets and a sparse low-order set
    for (int d = 0; d < 4; d++) begin
      for (int r = 0; r < 3; r++) begin
        @(negedge clk);
        for (int i = 0; i < 16; i++) pp_drv[i] = rand_pp();
        queue_vec(d, ref_prod(pp_drv));
        launch(d, $sformatf("sweep_p%0d_rand%0d", p_of(d), r));
        release_out(d, $sformatf("sweep_p%0d_rand%0d", p_of(d), r));
      end
      @(negedge clk);
      pp_drv = '0;
      for (int i = 0; i < 3; i++) pp_drv[i] = rand_pp();
      pp_drv[0] = 34'h2_0000_0005;
      queue_vec(d, ref_prod(pp_drv));
      launch(d, $sformatf("sweep_p%0d_sparse", p_of(d)));
      release_out(d, $sformatf("sweep_p%0d_sparse", p_of(d)));
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
